// File: rtl/pc_fetch_sequencer.sv
// RV32I fetch sequencer: owns the PC, issues one imem request at a time,
// presents fetched words to decode with valid/stall; handles redirects in flight.
// Optional macro PCSEQ_TRAP_EN: misaligned redirects go to TRAP_VEC instead of being dropped.
module pc_fetch_sequencer #(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC  = 32'h0000_0004
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_GNT,
  input  logic        IMEM_RVALID,
  input  logic [31:0] IMEM_RDATA,
  output logic        INSTR_VALID,
  output logic [31:0] INSTR,
  output logic [31:0] INSTR_PC,
  input  logic        STALL,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC,
  output logic [31:0] PC,
  output logic        MISALIGN
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_OUT} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_q, pc_nxt;
  logic        discard_q, discard_nxt;
  logic        vld_q, vld_nxt;
  logic [31:0] instr_q, instr_nxt;
  logic [31:0] ipc_q, ipc_nxt;
  logic        mis_q;

  logic        redir_mis;
  logic        redir_take;
  logic [31:0] redir_tgt;

  // A misaligned target selects the trap vector; whether it is acted on depends on the build.
  assign redir_mis = REDIRECT_PC[1:0] != 2'b00;
  assign redir_tgt = redir_mis ? TRAP_VEC : REDIRECT_PC;
`ifdef PCSEQ_TRAP_EN
  assign redir_take = REDIRECT;
`else
  assign redir_take = REDIRECT && !redir_mis;
`endif

  assign IMEM_REQ    = (state == S_REQ);
  assign IMEM_ADDR   = pc_q;
  assign PC          = pc_q;
  assign INSTR_VALID = vld_q;
  assign INSTR       = instr_q;
  assign INSTR_PC    = ipc_q;
  assign MISALIGN    = mis_q;

  // State and datapath registers, asynchronously reset to the boot state.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= S_IDLE;
      pc_q      <= BOOT_ADDR;
      discard_q <= 1'b0;
      vld_q     <= 1'b0;
      instr_q   <= 32'h0;
      ipc_q     <= 32'h0;
      mis_q     <= 1'b0;
    end else begin
      state     <= state_nxt;
      pc_q      <= pc_nxt;
      discard_q <= discard_nxt;
      vld_q     <= vld_nxt;
      instr_q   <= instr_nxt;
      ipc_q     <= ipc_nxt;
      mis_q     <= REDIRECT && redir_mis;
    end
  end

  // Next-state logic; a taken redirect overrides normal sequencing and stall.
  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc_q;
    discard_nxt = discard_q;
    vld_nxt     = vld_q;
    instr_nxt   = instr_q;
    ipc_nxt     = ipc_q;
    case (state)
      S_IDLE: begin
        state_nxt = S_REQ;
        if (redir_take) pc_nxt = redir_tgt;
      end
      S_REQ: begin
        if (redir_take) pc_nxt = redir_tgt;
        // A grant in the same cycle as a redirect fetched the old path: mark it stale.
        if (IMEM_GNT) begin
          state_nxt   = S_WAIT;
          discard_nxt = redir_take;
        end
      end
      S_WAIT: begin
        if (redir_take) begin
          pc_nxt = redir_tgt;
          if (IMEM_RVALID) begin
            discard_nxt = 1'b0;
            state_nxt   = S_REQ;
          end else begin
            discard_nxt = 1'b1;
          end
        end else if (IMEM_RVALID) begin
          if (discard_q) begin
            discard_nxt = 1'b0;
            state_nxt   = S_REQ;
          end else begin
            instr_nxt = IMEM_RDATA;
            ipc_nxt   = pc_q;
            vld_nxt   = 1'b1;
            state_nxt = S_OUT;
          end
        end
      end
      S_OUT: begin
        if (redir_take) begin
          pc_nxt    = redir_tgt;
          vld_nxt   = 1'b0;
          state_nxt = S_REQ;
        end else if (!STALL) begin
          pc_nxt    = pc_q + 32'd4;
          vld_nxt   = 1'b0;
          state_nxt = S_REQ;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Bench for pc_fetch_sequencer: cycle table of directed vectors plus a
// scoreboard fed by a small instruction-memory model.
module tb_pc_fetch_sequencer;

  logic        CLK = 1'b0;
  logic        RST;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_GNT;
  logic        IMEM_RVALID;
  logic [31:0] IMEM_RDATA;
  logic        INSTR_VALID;
  logic [31:0] INSTR;
  logic [31:0] INSTR_PC;
  logic        STALL;
  logic        REDIRECT;
  logic [31:0] REDIRECT_PC;
  logic [31:0] PC;
  logic        MISALIGN;

  always #5 CLK = ~CLK;

  pc_fetch_sequencer #(.BOOT_ADDR(32'h0000_1000)) dut (
    .CLK(CLK), .RST(RST),
    .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR), .IMEM_GNT(IMEM_GNT),
    .IMEM_RVALID(IMEM_RVALID), .IMEM_RDATA(IMEM_RDATA),
    .INSTR_VALID(INSTR_VALID), .INSTR(INSTR), .INSTR_PC(INSTR_PC),
    .STALL(STALL), .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC),
    .PC(PC), .MISALIGN(MISALIGN)
  );

`ifdef PCSEQ_TRAP_EN
  localparam logic [31:0] MIS_A = 32'h0000_0004;
`else
  localparam logic [31:0] MIS_A = 32'h0000_4000;
`endif

  typedef struct packed { logic [31:0] pc; logic [31:0] ins; } exp_t;
  // in = {stall, redirect, gnt, rvalid}; ex = {req, valid, misalign} after the edge
  typedef struct { logic [3:0] in; logic [31:0] rpc; logic [2:0] ex; logic [31:0] addr; logic [31:0] ipc; } vec_t;

  int          tests = 0;
  int          fails = 0;
  int          ndeliv = 0;
  int          cyc_n = 0;
  int          dcyc[8];
  logic [31:0] dpc[8];
  exp_t        exp_q[$];
  vec_t        vt[$];
  logic        auto_m, gnt_tab, rv_tab, pend, prev_vld;
  logic [31:0] pend_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h1004) ? 32'h0050_0093 : (a ^ 32'h5A5A_0013);
  endfunction

  function automatic logic redir_taken(input logic r, input logic [31:0] p);
`ifdef PCSEQ_TRAP_EN
    return r;
`else
    return r && (p[1:0] == 2'b00);
`endif
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check1(input string nm, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic row(input logic [3:0] in, input logic [31:0] rpc, input logic [2:0] ex,
                     input logic [31:0] addr, input logic [31:0] ipc);
    vec_t v;
    v.in = in; v.rpc = rpc; v.ex = ex; v.addr = addr; v.ipc = ipc;
    vt.push_back(v);
  endtask

  // Memory model and delivery monitor, evaluated mid-cycle on the falling edge.
  task automatic mem_and_monitor();
    logic g;
    exp_t e;
    if (INSTR_VALID && !prev_vld) begin
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL sb_unexpected: got instr at %h, expected none", INSTR_PC);
      end else begin
        e = exp_q.pop_front();
        check("sb_pc", INSTR_PC, e.pc);
        check("sb_instr", INSTR, e.ins);
      end
      if (ndeliv < 8) begin
        dpc[ndeliv]  = INSTR_PC;
        dcyc[ndeliv] = cyc_n;
      end
      ndeliv++;
    end
    prev_vld    = INSTR_VALID;
    g           = auto_m ? IMEM_REQ : gnt_tab;
    IMEM_GNT    = g;
    IMEM_RVALID = auto_m ? pend : rv_tab;
    IMEM_RDATA  = mem_word(pend_addr);
    if (RST) exp_q.delete();
    else if (redir_taken(REDIRECT, REDIRECT_PC)) exp_q.delete();
    else if (g && IMEM_REQ) exp_q.push_back({IMEM_ADDR, mem_word(IMEM_ADDR)});
    pend = g && IMEM_REQ && !RST;
    if (g && IMEM_REQ) pend_addr = IMEM_ADDR;
  endtask

  task automatic cyc();
    @(negedge CLK);
    mem_and_monitor();
    @(posedge CLK);
    #1;
    cyc_n++;
  endtask

  initial begin
    RST = 1'b1; STALL = 1'b0; REDIRECT = 1'b0; REDIRECT_PC = 32'h0;
    IMEM_GNT = 1'b0; IMEM_RVALID = 1'b0; IMEM_RDATA = 32'h0;
    auto_m = 1'b0; gnt_tab = 1'b0; rv_tab = 1'b0; pend = 1'b0; prev_vld = 1'b0;
    pend_addr = 32'h0;

    // straight line, stall hold, in-flight redirects, misalign, wrap
    row(4'b0000, 32'h0,        3'b100, 32'h1000, 32'h0);
    row(4'b0010, 32'h0,        3'b000, 32'h1000, 32'h0);
    row(4'b0001, 32'h0,        3'b010, 32'h1000, 32'h1000);
    row(4'b0000, 32'h0,        3'b100, 32'h1004, 32'h0);
    row(4'b0010, 32'h0,        3'b000, 32'h1004, 32'h0);
    row(4'b0001, 32'h0,        3'b010, 32'h1004, 32'h1004);
    row(4'b1000, 32'h0,        3'b010, 32'h1004, 32'h1004);
    row(4'b1010, 32'h0,        3'b010, 32'h1004, 32'h1004);
    row(4'b1001, 32'h0,        3'b010, 32'h1004, 32'h1004);
    row(4'b1000, 32'h0,        3'b010, 32'h1004, 32'h1004);
    row(4'b0000, 32'h0,        3'b100, 32'h1008, 32'h0);
    row(4'b0010, 32'h0,        3'b000, 32'h1008, 32'h0);
    row(4'b0100, 32'h2000,     3'b000, 32'h2000, 32'h0);
    row(4'b0001, 32'h0,        3'b100, 32'h2000, 32'h0);
    row(4'b0010, 32'h0,        3'b000, 32'h2000, 32'h0);
    row(4'b0001, 32'h0,        3'b010, 32'h2000, 32'h2000);
    row(4'b0000, 32'h0,        3'b100, 32'h2004, 32'h0);
    row(4'b0010, 32'h0,        3'b000, 32'h2004, 32'h0);
    row(4'b0101, 32'h3000,     3'b100, 32'h3000, 32'h0);
    row(4'b0010, 32'h0,        3'b000, 32'h3000, 32'h0);
    row(4'b0001, 32'h0,        3'b010, 32'h3000, 32'h3000);
    row(4'b1100, 32'h4000,     3'b100, 32'h4000, 32'h0);
    row(4'b0100, 32'h2002,     3'b101, MIS_A,    32'h0);
    row(4'b0000, 32'h0,        3'b100, MIS_A,    32'h0);
    row(4'b0110, 32'h5000,     3'b000, 32'h5000, 32'h0);
    row(4'b0001, 32'h0,        3'b100, 32'h5000, 32'h0);
    row(4'b0010, 32'h0,        3'b000, 32'h5000, 32'h0);
    row(4'b0001, 32'h0,        3'b010, 32'h5000, 32'h5000);
    row(4'b0100, 32'hFFFFFFFC, 3'b100, 32'hFFFFFFFC, 32'h0);
    row(4'b0010, 32'h0,        3'b000, 32'hFFFFFFFC, 32'h0);
    row(4'b0001, 32'h0,        3'b010, 32'hFFFFFFFC, 32'hFFFFFFFC);
    row(4'b0000, 32'h0,        3'b100, 32'h0,    32'h0);
    row(4'b0010, 32'h0,        3'b000, 32'h0,    32'h0);
    row(4'b0001, 32'h0,        3'b010, 32'h0,    32'h0);
    row(4'b0000, 32'h0,        3'b100, 32'h4,    32'h0);

    cyc(); cyc();
    check1("rst_req", IMEM_REQ, 1'b0);
    check("rst_pc", PC, 32'h1000);
    check1("rst_valid", INSTR_VALID, 1'b0);
    check("rst_instr", INSTR, 32'h0);
    check("rst_instr_pc", INSTR_PC, 32'h0);
    check1("rst_misalign", MISALIGN, 1'b0);
    RST = 1'b0;

    foreach (vt[i]) begin
      STALL = vt[i].in[3]; REDIRECT = vt[i].in[2]; REDIRECT_PC = vt[i].rpc;
      gnt_tab = vt[i].in[1]; rv_tab = vt[i].in[0];
      cyc();
      check1($sformatf("row%0d_req", i), IMEM_REQ, vt[i].ex[2]);
      check($sformatf("row%0d_addr", i), IMEM_ADDR, vt[i].addr);
      check($sformatf("row%0d_pc", i), PC, vt[i].addr);
      check1($sformatf("row%0d_valid", i), INSTR_VALID, vt[i].ex[1]);
      check1($sformatf("row%0d_misalign", i), MISALIGN, vt[i].ex[0]);
      if (vt[i].ex[1]) begin
        check($sformatf("row%0d_instr_pc", i), INSTR_PC, vt[i].ipc);
        check($sformatf("row%0d_instr", i), INSTR, mem_word(vt[i].ipc));
      end
    end
    STALL = 1'b0; REDIRECT = 1'b0; REDIRECT_PC = 32'h0; rv_tab = 1'b0;

    // async reset while waiting on a granted fetch, then a late rvalid in IDLE
    gnt_tab = 1'b1;
    cyc();
    gnt_tab = 1'b0;
    RST = 1'b1;
    #1;
    check1("async_rst_req", IMEM_REQ, 1'b0);
    check("async_rst_pc", PC, 32'h1000);
    check1("async_rst_valid", INSTR_VALID, 1'b0);
    cyc();
    RST = 1'b0;
    rv_tab = 1'b1;
    cyc();
    rv_tab = 1'b0;
    check1("late_rv_req", IMEM_REQ, 1'b1);
    check("late_rv_addr", IMEM_ADDR, 32'h1000);
    check1("late_rv_valid", INSTR_VALID, 1'b0);

    // zero-wait memory, no stall: one instruction every 3 cycles
    auto_m = 1'b1;
    ndeliv = 0;
    for (int k = 0; k < 40 && ndeliv < 4; k++) cyc();
    check("straight_count", ndeliv, 4);
    for (int i = 0; i < 4 && i < ndeliv; i++)
      check($sformatf("straight_pc%0d", i), dpc[i], 32'h1000 + 32'(4 * i));
    for (int i = 0; i < 3 && i + 1 < ndeliv; i++)
      check($sformatf("straight_gap%0d", i), dcyc[i+1] - dcyc[i], 32'd3);

    // random stalls and aligned redirects against the scoreboard
    ndeliv = 0;
    for (int k = 0; k < 80; k++) begin
      STALL       = ($urandom_range(0, 3) == 0);
      REDIRECT    = ($urandom_range(0, 15) == 0);
      REDIRECT_PC = $urandom_range(0, 1023) << 2;
      cyc();
    end
    STALL = 1'b0; REDIRECT = 1'b0;
    for (int k = 0; k < 10; k++) cyc();
    check1("random_progress", ndeliv > 5, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
